// File: rtl/pattern_gen_pkg.sv
// Shared encodings for the burst-oriented multi-lane pattern generator.
//   pt_mode_e : pattern mode selector values (i_pt_sel)
//   state_e   : control FSM states
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    PT_LFSR   = 3'd0,
    PT_CNT    = 3'd1,
    PT_ZERO   = 3'd2,
    PT_ONE    = 3'd3,
    PT_CHK55  = 3'd4,
    PT_CHKAA  = 3'd5,
    PT_WALK   = 3'd6,
    PT_TOGGLE = 3'd7
  } pt_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_lfsr.sv
// Per-lane Fibonacci LFSR.
//   i_sysclk, i_arstn : clock, async active-low reset (state resets to 0)
//   load, seed        : load seed (all-zero seed becomes all-ones, a zero LFSR would lock up)
//   enable            : advance one step
//   state             : current register value
//   state_nxt         : value the register takes at the next edge
module pattern_lfsr
  import pattern_gen_pkg::*;
#(
  parameter int unsigned    DW   = 8,
  parameter logic [DW-1:0]  TAPS = 8'hB8
) (
  input  logic          i_sysclk,
  input  logic          i_arstn,
  input  logic          load,
  input  logic          enable,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] state,
  output logic [DW-1:0] state_nxt
);

  logic [DW-1:0] state_q;

  always_comb begin
    state_nxt = state_q;
    if (load) begin
      state_nxt = (seed == '0) ? '1 : seed;
    end else if (enable) begin
      state_nxt = {state_q[DW-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= '0;
    end else begin
      state_q <= state_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pattern_gen_mc.sv
// Multi-lane burst test-pattern source with valid/ready output.
//   i_sysclk, i_arstn : clock, async active-low reset
//   i_start, i_abort  : start a burst (IDLE only) / terminate immediately (highest priority)
//   i_pt_sel, i_len, i_seed : pattern mode, beat count, seed/base; sampled on the start cycle
//   i_ready           : downstream ready
//   o_valid, o_data, o_last : beat stream; lane k at o_data[k*DW +: DW]
//   o_busy, o_done    : not-IDLE flag / one-cycle pulse after the last beat is accepted
module pattern_gen_mc
  import pattern_gen_pkg::*;
#(
  parameter int unsigned   DW        = 8,
  parameter int unsigned   NUM_LANE  = 4,
  parameter int unsigned   LENW      = 16,
  parameter logic [DW-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                   i_sysclk,
  input  logic                   i_arstn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [2:0]             i_pt_sel,
  input  logic [LENW-1:0]        i_len,
  input  logic [DW-1:0]          i_seed,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [NUM_LANE*DW-1:0] o_data,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned PW = (DW > 1) ? $clog2(DW) : 1;

  state_e                 state_q, state_d;
  pt_mode_e               mode_q, mode_d;
  logic [LENW-1:0]        len_q, cnt_q, cnt_d;
  logic [DW-1:0]          base_q, base_d;
  logic [PW-1:0]          pos_q, pos_d;
  logic                   tog_q, tog_d;
  logic [NUM_LANE*DW-1:0] data_q, data_d;
  logic [NUM_LANE*DW-1:0] lfsr_state, lfsr_nxt;
  logic                   xfer, adv, load, last;

  assign xfer = (state_q == RUN) && i_ready;
  assign adv  = xfer && !i_abort;
  assign load = (state_q == IDLE) && i_start && !i_abort && (i_len != '0);
  // cnt never exceeds len-1 while in RUN, so the full LENW range is usable
  assign last = (cnt_q == len_q - LENW'(1));

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (i_start) state_d = (i_len != '0) ? RUN : DONE;
        RUN:     if (xfer && last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    base_d = base_q;
    pos_d  = pos_q;
    tog_d  = tog_q;
    if (load) begin
      mode_d = pt_mode_e'(i_pt_sel);
      cnt_d  = '0;
      base_d = i_seed;
      pos_d  = '0;
      tog_d  = 1'b0;
    end else if (adv) begin
      cnt_d  = cnt_q + LENW'(1);
      base_d = base_q + DW'(NUM_LANE);
      pos_d  = (pos_q == PW'(DW - 1)) ? '0 : pos_q + PW'(1);
      tog_d  = ~tog_q;
    end
  end

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    pattern_lfsr #(
      .DW   (DW),
      .TAPS (LFSR_TAPS)
    ) u_lfsr (
      .i_sysclk  (i_sysclk),
      .i_arstn   (i_arstn),
      .load      (load),
      .enable    (adv),
      .seed      (i_seed ^ DW'(k)),
      .state     (lfsr_state[k*DW +: DW]),
      .state_nxt (lfsr_nxt[k*DW +: DW])
    );
  end

  // Output data is built from next-state generator values so o_data is a plain flop.
  always_comb begin
    data_d = '0;
    if (state_d == RUN) begin
      for (int k = 0; k < NUM_LANE; k++) begin
        unique case (mode_d)
          PT_LFSR:   data_d[k*DW +: DW] = (load || adv) ? lfsr_nxt[k*DW +: DW]
                                                        : lfsr_state[k*DW +: DW];
          PT_CNT:    data_d[k*DW +: DW] = base_d + DW'(k);
          PT_ZERO:   data_d[k*DW +: DW] = '0;
          PT_ONE:    data_d[k*DW +: DW] = '1;
          PT_CHK55:  data_d[k*DW +: DW] = {(DW/8){8'h55}};
          PT_CHKAA:  data_d[k*DW +: DW] = {(DW/8){8'hAA}};
          PT_WALK:   data_d[k*DW +: DW] = DW'(1) << pos_d;
          // even lanes start at 0x55, odd at 0xAA; tog flips every beat
          PT_TOGGLE: data_d[k*DW +: DW] = (((k % 2) == 0) != tog_d) ? {(DW/8){8'h55}}
                                                                    : {(DW/8){8'hAA}};
          default:   data_d[k*DW +: DW] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= IDLE;
      mode_q  <= PT_LFSR;
      len_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      pos_q   <= '0;
      tog_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      pos_q   <= pos_d;
      tog_q   <= tog_d;
      data_q  <= data_d;
      if (load) len_q <= i_len;
    end
  end

  assign o_valid = (state_q == RUN);
  assign o_last  = (state_q == RUN) && last;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_data  = data_q;

endmodule

// File: tb/tb_pattern_gen_mc.sv
// Directed, table-driven bench for pattern_gen_mc (default parameters: DW=8, 4 lanes).
module tb_pattern_gen_mc;

  logic        clk;
  logic        rst_n;
  logic        start, abort, ready;
  logic [2:0]  pt_sel;
  logic [15:0] len;
  logic [7:0]  seed;
  logic        valid, last, busy, done;
  logic [31:0] data;

  int n_pass  = 0;
  int n_total = 0;

  pattern_gen_mc dut (
    .i_sysclk (clk),
    .i_arstn  (rst_n),
    .i_start  (start),
    .i_abort  (abort),
    .i_pt_sel (pt_sel),
    .i_len    (len),
    .i_seed   (seed),
    .i_ready  (ready),
    .o_valid  (valid),
    .o_data   (data),
    .o_last   (last),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  seed;
    logic [15:0] len;
    bit          toggle;  // ready pattern 1,0,1,0... instead of always 1
    int          base;    // first entry in exp_data
  } burst_t;

  burst_t      bursts [9];
  logic [31:0] exp_data [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic run_burst(input int id);
    burst_t b;
    int beat;
    int cyc;
    bit rdy;
    b    = bursts[id];
    beat = 0;
    cyc  = 0;
    @(negedge clk);
    start = 1'b1; pt_sel = b.mode; len = b.len; seed = b.seed; ready = 1'b0;
    @(negedge clk);
    // scramble sampled inputs; they must be ignored after the start cycle
    start = 1'b0; pt_sel = 3'd2; len = 16'd0; seed = 8'hA5;
    while (beat < int'(b.len) && cyc < 64) begin
      chk($sformatf("b%0d.c%0d.valid", id, cyc), {31'd0, valid}, 32'd1);
      chk($sformatf("b%0d.beat%0d.data", id, beat), data, exp_data[b.base + beat]);
      chk($sformatf("b%0d.beat%0d.last", id, beat), {31'd0, last},
          {31'd0, (beat == int'(b.len) - 1)});
      rdy   = b.toggle ? ((cyc % 2) == 0) : 1'b1;
      ready = rdy;
      @(negedge clk);
      if (rdy) beat++;
      cyc++;
    end
    chk($sformatf("b%0d.beats_done", id), beat, {16'd0, b.len});
    ready = 1'b0;
    chk($sformatf("b%0d.done", id), {31'd0, done}, 32'd1);
    chk($sformatf("b%0d.valid_after", id), {31'd0, valid}, 32'd0);
    chk($sformatf("b%0d.data_after", id), data, 32'd0);
    @(negedge clk);
    chk($sformatf("b%0d.done_pulse", id), {31'd0, done}, 32'd0);
    chk($sformatf("b%0d.busy_idle", id), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bursts[0] = '{3'd1, 8'h10, 16'd3,  1'b0, 0};   // counter
    bursts[1] = '{3'd0, 8'h00, 16'd4,  1'b1, 3};   // LFSR, zero seed, backpressure
    bursts[2] = '{3'd6, 8'h00, 16'd10, 1'b0, 7};   // walking one
    bursts[3] = '{3'd7, 8'h00, 16'd2,  1'b1, 17};  // toggling checker
    bursts[4] = '{3'd2, 8'h00, 16'd1,  1'b0, 19};
    bursts[5] = '{3'd3, 8'h00, 16'd1,  1'b0, 20};
    bursts[6] = '{3'd4, 8'h00, 16'd1,  1'b0, 21};
    bursts[7] = '{3'd5, 8'h00, 16'd1,  1'b0, 22};
    bursts[8] = '{3'd1, 8'hFE, 16'd2,  1'b0, 23};  // counter wrap mod 256
    exp_data[0]  = 32'h13121110; exp_data[1]  = 32'h17161514; exp_data[2]  = 32'h1B1A1918;
    exp_data[3]  = 32'h030201FF; exp_data[4]  = 32'h060402FE;
    exp_data[5]  = 32'h0C0804FC; exp_data[6]  = 32'h191108F8;
    exp_data[7]  = 32'h01010101; exp_data[8]  = 32'h02020202; exp_data[9]  = 32'h04040404;
    exp_data[10] = 32'h08080808; exp_data[11] = 32'h10101010; exp_data[12] = 32'h20202020;
    exp_data[13] = 32'h40404040; exp_data[14] = 32'h80808080; exp_data[15] = 32'h01010101;
    exp_data[16] = 32'h02020202;
    exp_data[17] = 32'hAA55AA55; exp_data[18] = 32'h55AA55AA;
    exp_data[19] = 32'h00000000; exp_data[20] = 32'hFFFFFFFF;
    exp_data[21] = 32'h55555555; exp_data[22] = 32'hAAAAAAAA;
    exp_data[23] = 32'h0100FFFE; exp_data[24] = 32'h05040302;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    pt_sel = 3'd0; len = 16'd0; seed = 8'd0;
    #12;
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.data",  data, 32'd0);
    chk("rst.last",  {31'd0, last}, 32'd0);
    chk("rst.busy",  {31'd0, busy}, 32'd0);
    chk("rst.done",  {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_burst(i);

    // abort wins over start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pt_sel = 3'd1; len = 16'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start.busy",  {31'd0, busy}, 32'd0);
    chk("abort_start.valid", {31'd0, valid}, 32'd0);

    // zero-length start: straight to DONE, no beat
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0.valid", {31'd0, valid}, 32'd0);
    chk("len0.done",  {31'd0, done}, 32'd1);
    chk("len0.busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("len0.done_pulse", {31'd0, done}, 32'd0);
    chk("len0.busy_idle",  {31'd0, busy}, 32'd0);

    // start during RUN is ignored; data holds while ready low
    start = 1'b1; pt_sel = 3'd1; seed = 8'h10; len = 16'd3; ready = 1'b0;
    @(negedge clk);
    chk("rerun.beat0", data, 32'h13121110);
    start = 1'b1; pt_sel = 3'd2; seed = 8'h80; len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun.hold",  data, 32'h13121110);
    chk("rerun.last0", {31'd0, last}, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    chk("rerun.beat1", data, 32'h17161514);
    @(negedge clk);
    chk("rerun.beat2", data, 32'h1B1A1918);
    chk("rerun.last2", {31'd0, last}, 32'd1);
    @(negedge clk);
    ready = 1'b0;
    chk("rerun.done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // abort together with a transfer on beat 5
    start = 1'b1; pt_sel = 3'd3; len = 16'd100; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abort.beat%0d", i), data, 32'hFFFFFFFF);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; ready = 1'b0;
    chk("abort.valid", {31'd0, valid}, 32'd0);
    chk("abort.done",  {31'd0, done}, 32'd0);
    chk("abort.busy",  {31'd0, busy}, 32'd0);
    chk("abort.data",  data, 32'd0);
    @(negedge clk);
    chk("abort.no_late_done", {31'd0, done}, 32'd0);

    // maximum length: o_last must not fire early
    start = 1'b1; pt_sel = 3'd2; len = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("maxlen.valid", {31'd0, valid}, 32'd1);
    chk("maxlen.last",  {31'd0, last}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("maxlen.abort_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-burst
    start = 1'b1; pt_sel = 3'd5; len = 16'd10; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mrst.pre_valid", {31'd0, valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.valid", {31'd0, valid}, 32'd0);
    chk("mrst.data",  data, 32'd0);
    chk("mrst.busy",  {31'd0, busy}, 32'd0);
    chk("mrst.last",  {31'd0, last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b0;
    @(negedge clk);
    chk("mrst.idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pattern_gen_mc.md
Name: pattern_gen_mc

Overview:
- Multi-lane, burst-oriented test-pattern source for the CSI RX datapath testbench and on-chip BIST.
- Emits NUM_LANE lanes of DW bits per beat, from one of eight pattern modes, for a programmed number of beats.
- Uses a valid/ready handshake and signals start, last and done, so it can drive stream sinks that apply backpressure.

Parameters:
- DW, 8, per-lane data width in bits; must be a multiple of 8, minimum 8.
- NUM_LANE, 4, number of parallel lanes.
- LENW, 16, width of the burst-length field.
- LFSR_TAPS, 8'hB8, Fibonacci feedback mask, DW bits wide. The default is the DW=8 maximal-length mask.

Ports:
- i_sysclk  in  1  system clock; all logic is on its rising edge.
- i_arstn  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; starts a burst, honoured only in IDLE.
- i_abort  in  1  terminates the current burst immediately.
- i_pt_sel  in  3  pattern mode; sampled at start.
- i_len  in  LENW  burst length in beats; sampled at start.
- i_seed  in  DW  LFSR seed and counter base; sampled at start.
- i_ready  in  1  downstream ready.
- o_valid  out  1  beat valid.
- o_data  out  NUM_LANE*DW  beat data; lane k occupies bits [k*DW +: DW].
- o_last  out  1  high on the final beat of the burst.
- o_busy  out  1  high whenever state is not IDLE.
- o_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clock and reset: one clock, i_sysclk. Reset i_arstn is asynchronous, active-low.
- Reset values: state=IDLE; o_valid, o_last, o_busy and o_done all 0; o_data=0; all internal counters and LFSRs 0.
- States:
  - IDLE: i_start with i_len!=0 latches mode, length and seed, loads the generators and goes to RUN. o_valid rises on the next cycle, so latency start-to-first-valid is 1 cycle.
  - IDLE: i_start with i_len==0 goes to DONE; no beat is emitted.
  - RUN: o_valid=1. A beat transfers on a cycle where o_valid and i_ready are both high.
  - RUN: while o_valid=1 and i_ready=0, o_data and o_last hold stable.
  - RUN: when the beat with o_last=1 transfers, go to DONE.
  - DONE: o_done=1 for exactly one cycle, then return to IDLE.
- Beat counter: cnt counts transferred beats. o_last = (cnt == len-1). With len=1, o_last is high on the first beat.
- i_start outside IDLE is ignored. Mode, length and seed inputs are ignored outside the start cycle.
- i_abort in any state returns to IDLE on the next edge: o_valid=0, no o_done. i_abort has priority over a simultaneous transfer or i_start.
- Pattern modes. Generators advance only on a transfer.
  - Mode 0, LFSR: each lane has its own LFSR. Lane k is loaded with i_seed XOR k; an all-zero load is replaced by all-ones. Next state = {r[DW-2:0], ^(r & LFSR_TAPS)}. Output is the current state.
  - Mode 1, counter: lane k = base + k, where base starts at i_seed and increments by NUM_LANE per beat, modulo 2^DW.
  - Mode 2: all zeros.
  - Mode 3: all ones.
  - Mode 4: 0x55 replicated.
  - Mode 5: 0xAA replicated.
  - Mode 6, walking one: lane data = 1<<pos. pos starts at 0, increments per beat and wraps from DW-1 to 0. All lanes are identical.
  - Mode 7, toggling checker: beat 0 is 0x55 on even lanes and 0xAA on odd lanes; every subsequent beat is the bitwise inverse of the previous one.
- o_data is registered and is 0 whenever o_valid=0.
- Length wrap: i_len = 2^LENW - 1 is legal. The counter is LENW bits wide and must not overflow before o_last.

Decomposition:
- Shared package pattern_gen_pkg: mode encodings PT_LFSR=0, PT_CNT=1, PT_ZERO=2, PT_ONE=3, PT_CHK55=4, PT_CHKAA=5, PT_WALK=6, PT_TOGGLE=7, and the state encoding IDLE/RUN/DONE.
- One sub-module, pattern_lfsr (DW, TAPS): load, enable, seed inputs; state output; zero-seed substitution done inside it. Instantiated NUM_LANE times with a generate loop.

Test Plan:
- Mode 1, seed=8'h10, len=3, i_ready always 1 -> beats 10/11/12/13, 14/15/16/17, 18/19/1A/1B (lanes 0..3); o_last on beat 3; o_done one cycle after.
- Mode 0, seed=8'h00, len=4, i_ready toggling 1,0,1,0 -> lane 0 sequence FF,FF>>… matches the reference model using the substituted seed FF. Lane 1 is seeded 01. Data stays stable during every ready-low cycle.
- Mode 6, len=10, DW=8 -> lane data 01,02,04,…,80,01,02; o_last on the 10th beat.
- Mode 7, len=2 -> beat 0 = 55/AA/55/AA, beat 1 = AA/55/AA/55.
- i_len=0 start -> no o_valid; o_done one cycle later. i_start asserted during RUN -> ignored.
- Mode 3, len=100 -> i_abort asserted on beat 5 together with a transfer -> o_valid=0 next cycle, no o_done, o_busy=0. A reset pulse mid-burst -> all outputs 0 immediately.
